wb_stage_mq: RTL and testbench

- Parametrised successor to the single-lane writeback stage.
- Accepts up to NUM_CH retiring results per cycle from the MEM stage and buffers them in an in-order writeback queue.
- Drains one entry per cycle to the register-file write port.
- Provides a newest-match forwarding lookup over pending writes, and a registered unstall pulse tied to completion of staller-flagged instructions.

---
 rtl/wb_pkg.sv | 18 +
 rtl/wb_queue.sv | 91 +++++++++
 rtl/wb_stage_mq.sv | 107 ++++++++++
 tb/tb_wb_stage_mq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and helpers for the multi-lane writeback stage
package wb_pkg;

  localparam int WB_AW   = 5;
  localparam int WB_XLEN = 32;

  typedef struct packed {
    logic [WB_AW-1:0]   addr;
    logic [WB_XLEN-1:0] data;
    logic               staller;
  } wb_entry_t;

  // Bit offset of lane `lane` inside a flat bus of `width`-bit lanes.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - in-order writeback FIFO with compacting multi-lane push and newest-first lookup
module wb_queue
  import wb_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 4,
  parameter int AW     = WB_AW,
  parameter int XLEN   = WB_XLEN,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CH-1:0]      enq,
  input  logic [NUM_CH*AW-1:0]   enq_addr,
  input  logic [NUM_CH*XLEN-1:0] enq_data,
  input  logic [NUM_CH-1:0]      enq_staller,
  input  logic                   pop,
  output logic [AW-1:0]          head_addr,
  output logic [XLEN-1:0]        head_data,
  output logic                   head_staller,
  output logic [CW-1:0]          count,
  input  logic [AW-1:0]          lookup_addr,
  output logic                   lookup_hit,
  output logic [XLEN-1:0]        lookup_data
);

  logic [AW-1:0]    addr_mem [DEPTH];
  logic [XLEN-1:0]  data_mem [DEPTH];
  logic [DEPTH-1:0] stall_mem;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [PW-1:0]    slot [NUM_CH];
  logic [CW-1:0]    n_enq;
  logic             pop_ok;
  logic [PW-1:0]    idx;

  assign pop_ok = pop && (count != '0);

  // Each enqueuing lane lands after all lower-numbered enqueuing lanes.
  always_comb begin
    n_enq = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      slot[k] = tail + n_enq[PW-1:0];
      n_enq   = n_enq + CW'(enq[k]);
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (enq[k]) begin
        addr_mem[slot[k]]  <= enq_addr[lane_lsb(k, AW) +: AW];
        data_mem[slot[k]]  <= enq_data[lane_lsb(k, XLEN) +: XLEN];
        stall_mem[slot[k]] <= enq_staller[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop_ok) begin
        head <= head + PW'(1);
      end
      tail  <= tail + n_enq[PW-1:0];
      count <= count + n_enq - CW'(pop_ok);
    end
  end

  assign head_addr    = addr_mem[head];
  assign head_data    = data_mem[head];
  assign head_staller = stall_mem[head];

  // Walk oldest to newest so the youngest matching entry wins.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    idx         = '0;
    for (int j = 0; j < DEPTH; j++) begin
      idx = head + PW'(j);
      if ((CW'(j) < count) && (lookup_addr != '0) && (addr_mem[idx] == lookup_addr)) begin
        lookup_hit  = 1'b1;
        lookup_data = data_mem[idx];
      end
    end
  end

endmodule

// File: rtl/wb_stage_mq.sv
// rtl/wb_stage_mq.sv - multi-lane writeback stage: retire filter, queue, RF write port, forwarding, unstall
module wb_stage_mq
  import wb_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 4,
  parameter int AW     = WB_AW,
  parameter int XLEN   = WB_XLEN
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        i_valid,
  input  logic [NUM_CH-1:0]        i_rf_wr,
  input  logic [NUM_CH*AW-1:0]     i_rf_wr_addr,
  input  logic [NUM_CH*XLEN-1:0]   i_rf_wr_data,
  input  logic [NUM_CH*XLEN-1:0]   i_mem_data,
  input  logic [NUM_CH-1:0]        i_mem_to_reg,
  input  logic [NUM_CH-1:0]        i_staller,
  output logic                     o_ready,
  output logic                     o_wb_wr_reg_en,
  output logic [AW-1:0]            o_wb_wr_reg_addr,
  output logic [XLEN-1:0]          o_wb_wr_reg_data,
  input  logic [AW-1:0]            i_fwd_addr,
  output logic                     o_fwd_hit,
  output logic [XLEN-1:0]          o_fwd_data,
  output logic                     o_unstall,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic                   accept;
  logic                   pop;
  logic [NUM_CH-1:0]      accept_lanes;
  logic [NUM_CH-1:0]      addr_nz;
  logic [NUM_CH-1:0]      enq;
  logic [NUM_CH-1:0]      filtered_stall;
  logic [NUM_CH*XLEN-1:0] lane_data;
  logic [AW-1:0]          head_addr;
  logic [XLEN-1:0]        head_data;
  logic                   head_staller;
  logic                   q_hit;
  logic [XLEN-1:0]        q_data;
  logic                   wb_staller;

  // All-or-nothing acceptance against registered occupancy only.
  assign o_ready = rst_n && ((CW'(DEPTH) - o_count) >= CW'(NUM_CH));
  assign accept  = o_ready && (|i_valid);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    assign addr_nz[k] = |i_rf_wr_addr[lane_lsb(k, AW) +: AW];
    assign lane_data[lane_lsb(k, XLEN) +: XLEN] = i_mem_to_reg[k]
        ? i_mem_data[lane_lsb(k, XLEN) +: XLEN]
        : i_rf_wr_data[lane_lsb(k, XLEN) +: XLEN];
  end

  assign accept_lanes   = {NUM_CH{accept}} & i_valid;
  assign enq            = accept_lanes & i_rf_wr & addr_nz;
  assign filtered_stall = accept_lanes & ~enq & i_staller;
  assign pop            = (o_count != '0);

  wb_queue #(
    .NUM_CH (NUM_CH),
    .DEPTH  (DEPTH),
    .AW     (AW),
    .XLEN   (XLEN)
  ) u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .enq          (enq),
    .enq_addr     (i_rf_wr_addr),
    .enq_data     (lane_data),
    .enq_staller  (i_staller),
    .pop          (pop),
    .head_addr    (head_addr),
    .head_data    (head_data),
    .head_staller (head_staller),
    .count        (o_count),
    .lookup_addr  (i_fwd_addr),
    .lookup_hit   (q_hit),
    .lookup_data  (q_data)
  );

  // wb_staller marks a staller-flagged write sitting on the RF port; the
  // release pulse follows one cycle after that write becomes visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_wb_wr_reg_en   <= 1'b0;
      o_wb_wr_reg_addr <= '0;
      o_wb_wr_reg_data <= '0;
      wb_staller       <= 1'b0;
      o_unstall        <= 1'b0;
    end else begin
      o_wb_wr_reg_en <= pop;
      wb_staller     <= pop && head_staller;
      if (pop) begin
        o_wb_wr_reg_addr <= head_addr;
        o_wb_wr_reg_data <= head_data;
      end
      o_unstall <= wb_staller || (|filtered_stall);
    end
  end

  assign o_fwd_hit  = rst_n && q_hit;
  assign o_fwd_data = q_data;

endmodule

// File: tb/tb_wb_stage_mq.sv
// tb/tb_wb_stage_mq.sv - directed self-checking bench for wb_stage_mq
module tb_wb_stage_mq;
  import wb_pkg::*;

  localparam int NUM_CH = 2;
  localparam int DEPTH  = 4;
  localparam int AW     = 5;
  localparam int XLEN   = 32;
  localparam int CW     = 3;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NUM_CH-1:0]      i_valid;
  logic [NUM_CH-1:0]      i_rf_wr;
  logic [NUM_CH*AW-1:0]   i_rf_wr_addr;
  logic [NUM_CH*XLEN-1:0] i_rf_wr_data;
  logic [NUM_CH*XLEN-1:0] i_mem_data;
  logic [NUM_CH-1:0]      i_mem_to_reg;
  logic [NUM_CH-1:0]      i_staller;
  logic                   o_ready;
  logic                   o_wb_wr_reg_en;
  logic [AW-1:0]          o_wb_wr_reg_addr;
  logic [XLEN-1:0]        o_wb_wr_reg_data;
  logic [AW-1:0]          i_fwd_addr;
  logic                   o_fwd_hit;
  logic [XLEN-1:0]        o_fwd_data;
  logic                   o_unstall;
  logic [CW-1:0]          o_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_stage_mq #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .AW(AW), .XLEN(XLEN)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_valid          (i_valid),
    .i_rf_wr          (i_rf_wr),
    .i_rf_wr_addr     (i_rf_wr_addr),
    .i_rf_wr_data     (i_rf_wr_data),
    .i_mem_data       (i_mem_data),
    .i_mem_to_reg     (i_mem_to_reg),
    .i_staller        (i_staller),
    .o_ready          (o_ready),
    .o_wb_wr_reg_en   (o_wb_wr_reg_en),
    .o_wb_wr_reg_addr (o_wb_wr_reg_addr),
    .o_wb_wr_reg_data (o_wb_wr_reg_data),
    .i_fwd_addr       (i_fwd_addr),
    .o_fwd_hit        (o_fwd_hit),
    .o_fwd_data       (o_fwd_data),
    .o_unstall        (o_unstall),
    .o_count          (o_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_lanes;
    i_valid = '0; i_rf_wr = '0; i_rf_wr_addr = '0; i_rf_wr_data = '0;
    i_mem_data = '0; i_mem_to_reg = '0; i_staller = '0;
  endtask

  task automatic drive_lane(input int k, input logic v, input logic w, input logic [AW-1:0] a,
                            input logic [XLEN-1:0] rd, input logic [XLEN-1:0] md,
                            input logic m2r, input logic st);
    i_valid[k] = v; i_rf_wr[k] = w; i_rf_wr_addr[k*AW +: AW] = a;
    i_rf_wr_data[k*XLEN +: XLEN] = rd; i_mem_data[k*XLEN +: XLEN] = md;
    i_mem_to_reg[k] = m2r; i_staller[k] = st;
  endtask

  task automatic test_reset;
    clear_lanes();
    i_fwd_addr = 5'd0;
    rst_n = 1'b0;
    tick(); tick();
    total++; if (o_count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", o_count); end
    total++; if (o_wb_wr_reg_en !== 1'b0) begin bad++; $display("FAIL reset_en: got %0b want 0", o_wb_wr_reg_en); end
    total++; if (o_wb_wr_reg_addr !== 5'd0 || o_wb_wr_reg_data !== 32'd0) begin bad++; $display("FAIL reset_port: got %0h/%0h want 0/0", o_wb_wr_reg_addr, o_wb_wr_reg_data); end
    total++; if (o_unstall !== 1'b0) begin bad++; $display("FAIL reset_unstall: got %0b want 0", o_unstall); end
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_low: got %0b want 0", o_ready); end
    rst_n = 1'b1;
    #1;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_release: got %0b want 1", o_ready); end
  endtask

  task automatic test_dual;
    drive_lane(0, 1, 1, 5'd5, 32'h11, 32'hDEAD, 0, 0);
    drive_lane(1, 1, 1, 5'd6, 32'h99, 32'hAB, 1, 0);
    #1;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL dual_ready: got %0b want 1", o_ready); end
    tick();
    clear_lanes();
    total++; if (o_count !== 3'd2 || o_wb_wr_reg_en !== 1'b0) begin bad++; $display("FAIL dual_accept: got cnt=%0d en=%0b want cnt=2 en=0", o_count, o_wb_wr_reg_en); end
    tick();
    total++; if (o_wb_wr_reg_en !== 1'b1 || o_wb_wr_reg_addr !== 5'd5 || o_wb_wr_reg_data !== 32'h11) begin bad++; $display("FAIL dual_wr0: got en=%0b a=%0d d=%0h want 1/5/11", o_wb_wr_reg_en, o_wb_wr_reg_addr, o_wb_wr_reg_data); end
    tick();
    total++; if (o_wb_wr_reg_en !== 1'b1 || o_wb_wr_reg_addr !== 5'd6 || o_wb_wr_reg_data !== 32'hAB) begin bad++; $display("FAIL dual_wr1: got en=%0b a=%0d d=%0h want 1/6/ab", o_wb_wr_reg_en, o_wb_wr_reg_addr, o_wb_wr_reg_data); end
    total++; if (o_count !== 3'd0) begin bad++; $display("FAIL dual_drained: got %0d want 0", o_count); end
    tick();
    total++; if (o_wb_wr_reg_en !== 1'b0 || o_wb_wr_reg_addr !== 5'd6 || o_wb_wr_reg_data !== 32'hAB) begin bad++; $display("FAIL dual_hold: got en=%0b a=%0d d=%0h want 0/6/ab", o_wb_wr_reg_en, o_wb_wr_reg_addr, o_wb_wr_reg_data); end
    total++; if (o_unstall !== 1'b0) begin bad++; $display("FAIL dual_unstall: got %0b want 0", o_unstall); end
  endtask

  task automatic test_filter;
    drive_lane(0, 1, 1, 5'd0, 32'h55, 32'h0, 0, 0);
    drive_lane(1, 1, 0, 5'd3, 32'h77, 32'h0, 0, 1);
    #1;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL filter_ready: got %0b want 1", o_ready); end
    tick();
    clear_lanes();
    total++; if (o_count !== 3'd0) begin bad++; $display("FAIL filter_count: got %0d want 0", o_count); end
    total++; if (o_unstall !== 1'b1) begin bad++; $display("FAIL filter_unstall: got %0b want 1", o_unstall); end
    tick();
    total++; if (o_unstall !== 1'b0) begin bad++; $display("FAIL filter_unstall_clear: got %0b want 0", o_unstall); end
    total++; if (o_wb_wr_reg_en !== 1'b0) begin bad++; $display("FAIL filter_no_write: got %0b want 0", o_wb_wr_reg_en); end
  endtask

  task automatic test_backpressure;
    wb_entry_t exp_wr [6];
    int        ad [6];
    int        exp_cnt [8];
    ad      = '{1, 2, 3, 4, 10, 11};
    exp_cnt = '{2, 3, 2, 3, 2, 1, 0, 0};
    for (int i = 0; i < 6; i++) begin
      exp_wr[i].addr    = AW'(ad[i]);
      exp_wr[i].data    = 32'h100 + XLEN'(ad[i]);
      exp_wr[i].staller = 1'b0;
    end
    drive_lane(0, 1, 1, 5'd1, 32'h101, 32'h0, 0, 0);
    drive_lane(1, 1, 1, 5'd2, 32'h0, 32'h102, 1, 0);
    #1;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_start: got %0b want 1", o_ready); end
    for (int s = 0; s < 8; s++) begin
      tick();
      if (s == 0) begin
        drive_lane(0, 1, 1, 5'd3, 32'h103, 32'h0, 0, 0);
        drive_lane(1, 1, 1, 5'd4, 32'h104, 32'h0, 0, 0);
      end else if (s == 1) begin
        drive_lane(0, 1, 1, 5'd10, 32'h10A, 32'h0, 0, 0);
        drive_lane(1, 1, 1, 5'd11, 32'h10B, 32'h0, 0, 0);
      end else if (s == 3) begin
        clear_lanes();
      end
      #1;
      total++; if (o_count !== CW'(exp_cnt[s])) begin bad++; $display("FAIL bp_count[%0d]: got %0d want %0d", s, o_count, exp_cnt[s]); end
      total++; if (o_ready !== (exp_cnt[s] <= 2)) begin bad++; $display("FAIL bp_ready[%0d]: got %0b want %0b", s, o_ready, exp_cnt[s] <= 2); end
      if (s >= 1 && s <= 6) begin
        total++;
        if (o_wb_wr_reg_en !== 1'b1 || o_wb_wr_reg_addr !== exp_wr[s-1].addr || o_wb_wr_reg_data !== exp_wr[s-1].data) begin
          bad++; $display("FAIL bp_write[%0d]: got en=%0b a=%0d d=%0h want 1/%0d/%0h", s, o_wb_wr_reg_en, o_wb_wr_reg_addr, o_wb_wr_reg_data, exp_wr[s-1].addr, exp_wr[s-1].data);
        end
      end else begin
        total++; if (o_wb_wr_reg_en !== 1'b0) begin bad++; $display("FAIL bp_idle[%0d]: got %0b want 0", s, o_wb_wr_reg_en); end
      end
    end
  endtask

  task automatic test_forward;
    i_fwd_addr = 5'd7;
    drive_lane(0, 1, 1, 5'd7, 32'h1, 32'h0, 0, 0);
    drive_lane(1, 1, 1, 5'd7, 32'h0, 32'h2, 1, 0);
    #1;
    total++; if (o_fwd_hit !== 1'b0) begin bad++; $display("FAIL fwd_empty: got %0b want 0", o_fwd_hit); end
    tick();
    clear_lanes();
    #1;
    total++; if (o_fwd_hit !== 1'b1 || o_fwd_data !== 32'h2) begin bad++; $display("FAIL fwd_newest: got hit=%0b d=%0h want 1/2", o_fwd_hit, o_fwd_data); end
    i_fwd_addr = 5'd8; #1;
    total++; if (o_fwd_hit !== 1'b0) begin bad++; $display("FAIL fwd_miss: got %0b want 0", o_fwd_hit); end
    i_fwd_addr = 5'd0; #1;
    total++; if (o_fwd_hit !== 1'b0) begin bad++; $display("FAIL fwd_x0: got %0b want 0", o_fwd_hit); end
    i_fwd_addr = 5'd7;
    tick();
    total++; if (o_fwd_hit !== 1'b1 || o_fwd_data !== 32'h2) begin bad++; $display("FAIL fwd_one_left: got hit=%0b d=%0h want 1/2", o_fwd_hit, o_fwd_data); end
    total++; if (o_wb_wr_reg_addr !== 5'd7 || o_wb_wr_reg_data !== 32'h1) begin bad++; $display("FAIL fwd_wr_old: got a=%0d d=%0h want 7/1", o_wb_wr_reg_addr, o_wb_wr_reg_data); end
    tick();
    total++; if (o_fwd_hit !== 1'b0) begin bad++; $display("FAIL fwd_on_port: got %0b want 0", o_fwd_hit); end
    total++; if (o_wb_wr_reg_en !== 1'b1 || o_wb_wr_reg_data !== 32'h2) begin bad++; $display("FAIL fwd_wr_new: got en=%0b d=%0h want 1/2", o_wb_wr_reg_en, o_wb_wr_reg_data); end
    tick();
    total++; if (o_fwd_hit !== 1'b0) begin bad++; $display("FAIL fwd_drained: got %0b want 0", o_fwd_hit); end
  endtask

  task automatic test_staller;
    drive_lane(0, 1, 1, 5'd9, 32'h99, 32'h0, 0, 1);
    tick();
    clear_lanes();
    total++; if (o_count !== 3'd1 || o_wb_wr_reg_en !== 1'b0 || o_unstall !== 1'b0) begin bad++; $display("FAIL stall_t: got cnt=%0d en=%0b un=%0b want 1/0/0", o_count, o_wb_wr_reg_en, o_unstall); end
    tick();
    total++; if (o_wb_wr_reg_en !== 1'b1 || o_wb_wr_reg_addr !== 5'd9 || o_wb_wr_reg_data !== 32'h99) begin bad++; $display("FAIL stall_wr: got en=%0b a=%0d d=%0h want 1/9/99", o_wb_wr_reg_en, o_wb_wr_reg_addr, o_wb_wr_reg_data); end
    total++; if (o_unstall !== 1'b0) begin bad++; $display("FAIL stall_early: got %0b want 0", o_unstall); end
    tick();
    total++; if (o_unstall !== 1'b1 || o_wb_wr_reg_en !== 1'b0) begin bad++; $display("FAIL stall_pulse: got un=%0b en=%0b want 1/0", o_unstall, o_wb_wr_reg_en); end
    tick();
    total++; if (o_unstall !== 1'b0) begin bad++; $display("FAIL stall_single: got %0b want 0", o_unstall); end
  endtask

  task automatic test_reset_mid;
    drive_lane(0, 1, 1, 5'd12, 32'hC, 32'h0, 0, 1);
    drive_lane(1, 1, 1, 5'd13, 32'hD, 32'h0, 0, 0);
    tick();
    total++; if (o_count !== 3'd2) begin bad++; $display("FAIL rmid_loaded: got %0d want 2", o_count); end
    rst_n = 1'b0;
    i_fwd_addr = 5'd12;
    #1;
    total++; if (o_ready !== 1'b0 || o_fwd_hit !== 1'b0) begin bad++; $display("FAIL rmid_gated: got rdy=%0b hit=%0b want 0/0", o_ready, o_fwd_hit); end
    tick();
    total++; if (o_count !== 3'd0 || o_wb_wr_reg_en !== 1'b0 || o_unstall !== 1'b0) begin bad++; $display("FAIL rmid_cleared: got cnt=%0d en=%0b un=%0b want 0/0/0", o_count, o_wb_wr_reg_en, o_unstall); end
    rst_n = 1'b1;
    clear_lanes();
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (o_wb_wr_reg_en !== 1'b0 || o_count !== 3'd0) begin bad++; $display("FAIL rmid_no_write[%0d]: got en=%0b cnt=%0d want 0/0", i, o_wb_wr_reg_en, o_count); end
    end
  endtask

  initial begin
    clear_lanes();
    i_fwd_addr = '0;
    test_reset();
    test_dual();
    test_filter();
    test_backpressure();
    test_forward();
    test_staller();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
